pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, pc value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, pc value loaded on trap (PC_SEQ_TRAP_EN only).
REQ-003 Parameter FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before fault.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 run  input  1  level; permits leaving IDLE and starting the next fetch.
REQ-007 halt  input  1  sampled with exec_done; stops the sequencer after the current instruction.
REQ-008 imem_req  output  1  instruction memory request, held high for the whole FETCH state.
REQ-009 imem_addr  output  32  fetch address, always equal to pc.
REQ-010 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 instr  output  32  registered instruction for the datapath.
REQ-013 instr_valid  output  1  one-cycle pulse on the first EXEC cycle.
REQ-014 exec_done  input  1  datapath has finished the current instruction.
REQ-015 branch_taken  input  1  sampled with exec_done; select branch_target as next pc.
REQ-016 branch_target  input  32  redirect address.
REQ-017 trap  input  1  sampled in EXEC; exception request.
REQ-018 pc  output  32  current program counter, byte address.
REQ-019 epc  output  32  pc of trapping instruction.
REQ-020 retire_count  output  32  number of completed instructions.
REQ-021 state  output  2  IDLE=00, FETCH=01, EXEC=10, HALTED=11.
REQ-022 fault  output  1  sticky; set on fetch timeout.

Function
REQ-023 IDLE: run=1 -> FETCH next cycle; run=0 -> stay; imem_req=0.
REQ-024 FETCH: imem_req=1, imem_addr=pc; on imem_ack instr<=imem_rdata, -> EXEC next cycle.
REQ-025 FETCH timeout: wait counter resets on FETCH entry; ack absent for FETCH_TIMEOUT consecutive cycles -> HALTED, fault=1; ack in the final allowed cycle is accepted.
REQ-026 EXEC: instr_valid=1 on first EXEC cycle only; stay until exec_done or trap.
REQ-027 exec_done: pc<=branch_taken ? branch_target : pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); retire_count+=1 (wraps); next state HALTED if halt, else FETCH if run, else IDLE.
REQ-028 branch_target[1:0] forced to 2'b00 when loaded unless REQ-033 applies.
REQ-029 pc[1:0] always 2'b00; pc changes only on exec_done, trap or reset.
REQ-030 HALTED: no requests, all registers hold; exit only via reset.
REQ-031 exec_done and imem_ack outside their states are ignored.

Reset
REQ-032 reset asserted at any time (including mid-FETCH) -> same cycle: state=IDLE, pc=RESET_VECTOR, imem_req=0, instr=0, instr_valid=0, epc=0, retire_count=0, fault=0, timeout counter=0.

Configuration
REQ-033 PC_SEQ_TRAP_EN defined: trap=1 in EXEC (priority over exec_done) -> epc<=pc, pc<=TRAP_VECTOR, retire_count unchanged, -> FETCH if run else IDLE; taken branch with branch_target[1:0]!=0 treated as trap (epc=pc of branch).
REQ-034 PC_SEQ_TRAP_EN undefined: trap ignored, epc constant 0, misaligned targets truncated per REQ-028.

Verification
REQ-035 Reset, run=1, ack on 2nd FETCH cycle, exec_done, no branch -> imem_addr 0 then 4, retire_count=1, instr_valid one pulse per instruction.
REQ-036 pc=0x40, exec_done+branch_taken, target 0x80 -> next imem_addr 0x80; target 0x82 without macro -> 0x80.
REQ-037 No imem_ack for 16 cycles -> state=11, fault=1, imem_req=0; ack on cycle 16 instead -> EXEC, fault=0.
REQ-038 Macro on, pc=0x20, trap and exec_done together -> epc=0x20, pc=0x100, retire_count unchanged.
REQ-039 Reset asserted mid-FETCH at pc=0x1C -> immediately pc=0, state=00, imem_req=0; exec_done+halt -> HALTED, run ignored thereafter.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake bundle between the pc sequencer and its memory/datapath.
interface pc_seq_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, exec_done, branch_taken, branch_target, trap
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, exec_done, branch_taken, branch_target, trap
  );
endinterface

// File: rtl/pc_sequencer.sv
// IDLE/FETCH/EXEC/HALTED program counter sequencer with fetch timeout fault.
// Optional trap support (epc, trap vector, misaligned-branch trap) under PC_SEQ_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt,
  pc_seq_if.master    bus,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] retire_count,
  output logic [1:0]  state,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE = 2'b00, FETCH = 2'b01, EXEC = 2'b10, HALTED = 2'b11} state_t;

  localparam int          CW      = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(FETCH_TIMEOUT - 1);
  localparam logic [31:0] RST_PC  = RESET_VECTOR & 32'hFFFF_FFFC;
  localparam logic [31:0] TRAP_PC = TRAP_VECTOR & 32'hFFFF_FFFC;

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   instr_q;
  logic          ivld_q;
  logic          trap_take, retire_ev, fetch_to;

`ifdef PC_SEQ_TRAP_EN
  // A taken branch to a non-word address is promoted to a trap.
  assign trap_take = (cur == EXEC) &&
                     (bus.trap || (bus.exec_done && bus.branch_taken && (|bus.branch_target[1:0])));
`else
  logic unused_trap;
  assign trap_take   = 1'b0;
  assign unused_trap = &{1'b0, bus.trap, bus.branch_target[1:0], TRAP_PC};
`endif

  assign retire_ev = (cur == EXEC) && bus.exec_done && !trap_take;
  assign fetch_to  = (cur == FETCH) && !bus.imem_ack && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:   if (run) nxt = FETCH;
      FETCH:  if (bus.imem_ack) nxt = EXEC;
              else if (fetch_to) nxt = HALTED;
      EXEC:   if (trap_take) nxt = run ? FETCH : IDLE;
              else if (bus.exec_done) nxt = halt ? HALTED : (run ? FETCH : IDLE);
      default: nxt = HALTED;
    endcase
  end

  always_comb begin
    bus.imem_req    = (cur == FETCH);
    bus.imem_addr   = pc;
    bus.instr       = instr_q;
    bus.instr_valid = ivld_q;
    state           = cur;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RST_PC;
      retire_count <= '0;
      instr_q      <= '0;
      ivld_q       <= 1'b0;
      fault        <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      ivld_q <= (cur == FETCH) && bus.imem_ack;
      if ((cur == FETCH) && bus.imem_ack) instr_q <= bus.imem_rdata;
      // Counter is zero on every FETCH entry; HALTED freezes everything.
      if (cur == FETCH)       wait_cnt <= wait_cnt + 1'b1;
      else if (cur != HALTED) wait_cnt <= '0;
      if (fetch_to) fault <= 1'b1;
      if (trap_take) begin
        pc <= TRAP_PC;
      end else if (retire_ev) begin
        pc           <= bus.branch_taken ? {bus.branch_target[31:2], 2'b00} : pc + 32'd4;
        retire_count <= retire_count + 32'd1;
      end
    end
  end

`ifdef PC_SEQ_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          epc <= '0;
    else if (trap_take) epc <= pc;
  end
`else
  assign epc = '0;
`endif
endmodule
